reg_file_param: RTL and testbench

Parametrised multi-port register file: the next-generation datapath register file for the microcontroller. Generalises the fixed 4×8 file to WIDTH×2^AW entries. Adds concurrent read/write with write-to-read forwarding, a read enable, an optional hardwired-zero entry 0, and a sequenced bulk-clear engine with a busy indication. Sits between the ALU result bus (X) and the ALU operand inputs (A, B).

---
 rtl/reg_file_param.sv | 99 +++++++++
 tb/tb_reg_file_param.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/reg_file_param.sv
// reg_file_param: parametrised WIDTH x 2^AW register file with two registered
// read ports (A, B), one write port (X), write-to-read forwarding, optional
// hardwired-zero entry 0 and a sequenced bulk-clear engine flagged by busy.
module reg_file_param #(
  parameter int WIDTH    = 8,
  parameter int AW       = 2,
  parameter bit ZERO_REG = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] X,
  input  logic [AW-1:0]    XADDR,
  input  logic             write,
  input  logic [AW-1:0]    AADDR,
  input  logic [AW-1:0]    BADDR,
  input  logic             read,
  input  logic             clr_req,
  output logic [WIDTH-1:0] A,
  output logic [WIDTH-1:0] B,
  output logic             busy
);

  localparam int unsigned DEPTH = 1 << AW;
  localparam logic [AW-1:0] LAST = '1;

  typedef enum logic {
    IDLE,
    CLEAR
  } state_t;

  state_t           state, state_n;
  logic [AW-1:0]    ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_a, rd_b;
  logic             idle;
  logic             wr_en;
  logic             rd_en;

  assign idle  = (state == IDLE);
  assign wr_en = idle && write && !(ZERO_REG && (XADDR == '0));
  assign rd_en = idle && read;

  // Next-state: clr_req only honoured in IDLE; CLEAR ends after the last entry
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (clr_req) state_n = CLEAR;
      CLEAR:   if (ptr == LAST) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // State register, clear pointer and busy flag
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      ptr   <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_n;
      busy  <= (state_n == CLEAR);
      if (state == CLEAR && ptr != LAST) ptr <= ptr + AW'(1);
      else                               ptr <= '0;
    end
  end

  // Storage array: normal writes in IDLE, one entry zeroed per cycle in CLEAR
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == CLEAR) begin
      mem[ptr] <= '0;
    end else if (wr_en) begin
      mem[XADDR] <= X;
    end
  end

  // Read muxes: same-cycle write data is forwarded; hardwired zero overrides
  always_comb begin
    rd_a = mem[AADDR];
    rd_b = mem[BADDR];
    if (write && (AADDR == XADDR)) rd_a = X;
    if (write && (BADDR == XADDR)) rd_b = X;
    if (ZERO_REG && (AADDR == '0)) rd_a = '0;
    if (ZERO_REG && (BADDR == '0)) rd_b = '0;
  end

  // Registered read ports; hold when not reading or while clearing
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      A <= '0;
      B <= '0;
    end else if (rd_en) begin
      A <= rd_a;
      B <= rd_b;
    end
  end

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default 8x4 instance plus a 16x8
// hardwired-zero instance, checked with immediate assertions.
module tb_reg_file_param;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Default instance
  logic [7:0] d_x, d_a, d_b;
  logic [1:0] d_xaddr, d_aaddr, d_baddr;
  logic       d_write, d_read, d_clr, d_busy;

  // ZERO_REG instance
  logic [15:0] z_x, z_a, z_b;
  logic [2:0]  z_xaddr, z_aaddr, z_baddr;
  logic        z_write, z_read, z_clr, z_busy;

  int checks   = 0;
  int failures = 0;

  reg_file_param u_def (
    .clk(clk), .rst(rst), .X(d_x), .XADDR(d_xaddr), .write(d_write),
    .AADDR(d_aaddr), .BADDR(d_baddr), .read(d_read), .clr_req(d_clr),
    .A(d_a), .B(d_b), .busy(d_busy)
  );

  reg_file_param #(.WIDTH(16), .AW(3), .ZERO_REG(1'b1)) u_zero (
    .clk(clk), .rst(rst), .X(z_x), .XADDR(z_xaddr), .write(z_write),
    .AADDR(z_aaddr), .BADDR(z_baddr), .read(z_read), .clr_req(z_clr),
    .A(z_a), .B(z_b), .busy(z_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dset(input logic wr, input logic [1:0] xa, input logic [7:0] xd,
                      input logic rd, input logic [1:0] aa, input logic [1:0] ba,
                      input logic cl);
    d_write = wr; d_xaddr = xa; d_x = xd;
    d_read = rd; d_aaddr = aa; d_baddr = ba; d_clr = cl;
  endtask

  task automatic zset(input logic wr, input logic [2:0] xa, input logic [15:0] xd,
                      input logic rd, input logic [2:0] aa, input logic [2:0] ba,
                      input logic cl);
    z_write = wr; z_xaddr = xa; z_x = xd;
    z_read = rd; z_aaddr = aa; z_baddr = ba; z_clr = cl;
  endtask

  initial begin
    dset(0, 0, 8'h00, 0, 0, 0, 0);
    zset(0, 0, 16'h0000, 0, 0, 0, 0);

    // Reset state
    #12;
    chk("rst_A", {24'b0, d_a}, 32'h0);
    chk("rst_B", {24'b0, d_b}, 32'h0);
    chk("rst_busy", {31'b0, d_busy}, 32'h0);
    rst = 1'b1;

    // Read before any write
    dset(0, 0, 8'h00, 1, 1, 2, 0); cyc();
    chk("empty_A", {24'b0, d_a}, 32'h0);
    chk("empty_B", {24'b0, d_b}, 32'h0);

    // Basic write then read
    dset(1, 1, 8'hA5, 0, 0, 0, 0); cyc();
    dset(1, 2, 8'h3C, 0, 0, 0, 0); cyc();
    dset(0, 0, 8'h00, 1, 1, 2, 0); cyc();
    chk("basic_A", {24'b0, d_a}, 32'hA5);
    chk("basic_B", {24'b0, d_b}, 32'h3C);

    // Forwarding
    dset(1, 3, 8'h77, 1, 3, 0, 0); cyc();
    chk("fwd_A", {24'b0, d_a}, 32'h77);
    chk("fwd_B", {24'b0, d_b}, 32'h00);
    dset(0, 0, 8'h00, 1, 3, 3, 0); cyc();
    chk("fwd_next_A", {24'b0, d_a}, 32'h77);
    chk("fwd_next_B", {24'b0, d_b}, 32'h77);

    // Read hold while overwriting the last-read entry
    dset(1, 3, 8'h11, 0, 3, 3, 0); cyc();
    chk("hold_A", {24'b0, d_a}, 32'h77);
    chk("hold_B", {24'b0, d_b}, 32'h77);
    dset(0, 0, 8'h00, 1, 3, 1, 0); cyc();
    chk("unhold_A", {24'b0, d_a}, 32'h11);
    chk("unhold_B", {24'b0, d_b}, 32'hA5);

    // Write and read to different addresses in one cycle (fills entry 0)
    dset(1, 0, 8'h5A, 1, 2, 1, 0); cyc();
    chk("indep_A", {24'b0, d_a}, 32'h3C);
    chk("indep_B", {24'b0, d_b}, 32'hA5);

    // Bulk clear with a simultaneous write; then writes/reads during busy
    dset(1, 2, 8'hC3, 0, 0, 0, 1); cyc();
    chk("clr_busy_1", {31'b0, d_busy}, 32'h1);
    dset(1, 1, 8'hFF, 1, 1, 2, 0);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("clr_busy_n", {31'b0, d_busy}, 32'h1);
      chk("clr_hold_A", {24'b0, d_a}, 32'h3C);
    end
    cyc();
    chk("clr_busy_end", {31'b0, d_busy}, 32'h0);
    chk("clr_end_hold_B", {24'b0, d_b}, 32'hA5);
    dset(0, 0, 8'h00, 1, 0, 1, 0); cyc();
    chk("clr_rd0", {24'b0, d_a}, 32'h0);
    chk("clr_rd1", {24'b0, d_b}, 32'h0);
    dset(0, 0, 8'h00, 1, 2, 3, 0); cyc();
    chk("clr_rd2", {24'b0, d_a}, 32'h0);
    chk("clr_rd3", {24'b0, d_b}, 32'h0);

    // Reset during the second busy cycle
    dset(1, 1, 8'h99, 1, 1, 1, 0); cyc();
    chk("pre_rst_A", {24'b0, d_a}, 32'h99);
    dset(0, 0, 8'h00, 0, 0, 0, 1); cyc();
    dset(0, 0, 8'h00, 0, 0, 0, 0); cyc();
    chk("mid_busy", {31'b0, d_busy}, 32'h1);
    #2 rst = 1'b0;
    #1;
    chk("async_busy", {31'b0, d_busy}, 32'h0);
    chk("async_A", {24'b0, d_a}, 32'h0);
    chk("async_B", {24'b0, d_b}, 32'h0);
    rst = 1'b1;
    #1;
    chk("post_rst_busy", {31'b0, d_busy}, 32'h0);
    dset(1, 2, 8'h42, 1, 2, 1, 0); cyc();
    chk("post_rst_A", {24'b0, d_a}, 32'h42);
    chk("post_rst_B", {24'b0, d_b}, 32'h0);
    dset(0, 0, 8'h00, 1, 0, 3, 0); cyc();
    chk("post_rst_rd0", {24'b0, d_a}, 32'h0);
    chk("post_rst_rd3", {24'b0, d_b}, 32'h0);
    dset(0, 0, 8'h00, 0, 0, 0, 0);

    // ZERO_REG instance
    zset(1, 0, 16'hBEEF, 0, 0, 0, 0); cyc();
    zset(1, 7, 16'h1234, 0, 0, 0, 0); cyc();
    zset(0, 0, 16'h0000, 1, 0, 7, 0); cyc();
    chk("z_rd0", {16'b0, z_a}, 32'h0);
    chk("z_rd7", {16'b0, z_b}, 32'h1234);
    zset(1, 0, 16'hFFFF, 1, 0, 0, 0); cyc();
    chk("z_fwd0_A", {16'b0, z_a}, 32'h0);
    chk("z_fwd0_B", {16'b0, z_b}, 32'h0);
    zset(1, 7, 16'hABCD, 1, 7, 0, 0); cyc();
    chk("z_fwd7_A", {16'b0, z_a}, 32'hABCD);
    chk("z_fwd7_B", {16'b0, z_b}, 32'h0);
    zset(0, 0, 16'h0000, 0, 0, 0, 1); cyc();
    chk("z_busy_1", {31'b0, z_busy}, 32'h1);
    zset(0, 0, 16'h0000, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk("z_busy_n", {31'b0, z_busy}, 32'h1);
    end
    cyc();
    chk("z_busy_end", {31'b0, z_busy}, 32'h0);
    zset(0, 0, 16'h0000, 1, 7, 0, 0); cyc();
    chk("z_clr_rd7", {16'b0, z_a}, 32'h0);
    chk("z_clr_rd0", {16'b0, z_b}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
